// File: rtl/s2p_symbol_scheduler.sv
// Read-side sequencer for the depuncturing serial-to-parallel buffer.
// Tracks filled mother-code slots as coded bits arrive and issues read_en
// in bursts of one OFDM symbol (N_DBPS pairs). At end of frame it flushes
// the partial tail. Overflow raises a sticky error flag.
module s2p_symbol_scheduler #(
    parameter int DEPTH = 501,
    parameter int CW    = 14
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] mod_sel,
    input  logic       wr_valid,
    input  logic       wr_last,
    input  logic       dst_ready,
    output logic       read_en,
    output logic       sym_start,
    output logic       sym_end,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, FILL, BURST, FLUSH, DONE} state_t;

    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    state_t        state;
    logic [1:0]    mode_q;
    logic [CW-1:0] ndbps;
    logic [CW-1:0] avail;
    logic [CW-1:0] pair_cnt;
    logic [1:0]    pat;
    logic          last_seen;
    logic          first_rd;

    logic          wr_acc;
    logic [1:0]    add;
    logic [1:0]    pat_nxt;
    logic [CW:0]   sum;
    logic [CW:0]   diff;
    logic          ovf;
    logic [CW-1:0] avail_nxt;
    logic [CW:0]   need;
    logic [CW:0]   half_up;

    // Data bits per symbol for a puncture rate / constellation pair.
    // Illegal rate 3 is folded to rate 1/2.
    function automatic logic [CW-1:0] ndbps_lut(input logic [1:0] m, input logic [1:0] s);
        logic [CW-1:0] r;
        case ({m, s})
            4'b01_00: r = CW'(36);
            4'b01_01: r = CW'(72);
            4'b01_10: r = CW'(144);
            4'b01_11: r = CW'(216);
            4'b10_00: r = CW'(32);
            4'b10_01: r = CW'(64);
            4'b10_10: r = CW'(128);
            4'b10_11: r = CW'(192);
            default: begin
                case (s)
                    2'd0:    r = CW'(24);
                    2'd1:    r = CW'(48);
                    2'd2:    r = CW'(96);
                    default: r = CW'(144);
                endcase
            end
        endcase
        return r;
    endfunction

    // Mealy read strobe and per-burst markers; status follows state.
    assign read_en   = ((state == BURST) || (state == FLUSH)) && dst_ready;
    assign sym_start = read_en && first_rd;
    assign sym_end   = read_en && (pair_cnt == CW'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Slot accounting: expand each written bit to its mother-code slots, retire two per read.
    always_comb begin
        wr_acc  = wr_valid && ((state == FILL) || (state == BURST) || (state == FLUSH));
        add     = 2'd0;
        pat_nxt = pat;
        if (wr_acc) begin
            case (mode_q)
                2'd1: begin
                    add     = (pat == 2'd2) ? 2'd3 : 2'd1;
                    pat_nxt = (pat == 2'd3) ? 2'd0 : pat + 2'd1;
                end
                2'd2: begin
                    add     = (pat == 2'd2) ? 2'd2 : 2'd1;
                    pat_nxt = (pat == 2'd2) ? 2'd0 : pat + 2'd1;
                end
                default: begin
                    add     = 2'd1;
                    pat_nxt = 2'd0;
                end
            endcase
        end
        sum = {1'b0, avail} + {{(CW-1){1'b0}}, add};
        if (read_en)
            diff = (sum >= (CW+1)'(2)) ? sum - (CW+1)'(2) : '0;
        else
            diff = sum;
        ovf       = (diff > DEPTH_W);
        avail_nxt = ovf ? DEPTH_W[CW-1:0] : diff[CW-1:0];
        need      = {ndbps, 1'b0};
        half_up   = ({1'b0, avail} + (CW+1)'(1)) >> 1;
    end

    // Frame sequencer plus slot/pair bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            ndbps     <= '0;
            avail     <= '0;
            pair_cnt  <= '0;
            pat       <= 2'd0;
            last_seen <= 1'b0;
            first_rd  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if ((state == FILL) || (state == BURST) || (state == FLUSH)) begin
                avail <= avail_nxt;
                pat   <= pat_nxt;
                if (ovf)
                    err <= 1'b1;
                if (wr_acc && wr_last)
                    last_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
                        ndbps     <= ndbps_lut(mode, mod_sel);
                        avail     <= '0;
                        pat       <= 2'd0;
                        pair_cnt  <= '0;
                        last_seen <= 1'b0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (({1'b0, avail} >= need) && dst_ready) begin
                        state    <= BURST;
                        pair_cnt <= ndbps;
                        first_rd <= 1'b1;
                    end else if (last_seen && ({1'b0, avail} < need)) begin
                        if (avail != '0) begin
                            state    <= FLUSH;
                            pair_cnt <= half_up[CW-1:0];
                            first_rd <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                BURST, FLUSH: begin
                    if (read_en) begin
                        pair_cnt <= pair_cnt - CW'(1);
                        first_rd <= 1'b0;
                        if (pair_cnt == CW'(1))
                            state <= (state == BURST) ? FILL : DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_symbol_scheduler.sv
// Directed bench for s2p_symbol_scheduler: a table of whole-frame scenarios
// plus hand sequences for reset, overflow timing and reset mid-burst.
module tb_s2p_symbol_scheduler;

    logic       clock = 1'b0;
    logic       reset, start, wr_valid, wr_last, dst_ready;
    logic [1:0] mode, mod_sel;
    logic       read_en, sym_start, sym_end, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] ms;
        int         nbits;
        bit         last;
        bit         tog;
        int         rd;
        int         ss;
        int         se;
        int         dn;
        int         span;
        bit         er;
        bit         by;
    } vec_t;

    vec_t tbl[12];

    s2p_symbol_scheduler dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .mod_sel(mod_sel),
        .wr_valid(wr_valid), .wr_last(wr_last), .dst_ready(dst_ready),
        .read_en(read_en), .sym_start(sym_start), .sym_end(sym_end),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; dst_ready = 1'b0;
        mode = 2'd0; mod_sel = 2'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Start a frame, write all bits with the sink stalled, then release the sink and observe.
    task automatic run_vec(input int idx, input bit rst_first);
        vec_t v;
        int nrd, nss, nse, ndn, first, last;
        bit ss1, sel, chkb;
        v = tbl[idx];
        nrd = 0; nss = 0; nse = 0; ndn = 0; first = 0; last = 0;
        ss1 = 1'b0; sel = 1'b0; chkb = 1'b0;
        if (rst_first) do_reset();
        dst_ready = 1'b0; mode = v.mode; mod_sel = v.ms; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < v.nbits; i++) begin
            wr_valid = 1'b1;
            wr_last  = v.last && (i == v.nbits - 1);
            @(negedge clock);
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            dst_ready = v.tog ? (c % 2 == 0) : 1'b1;
            #1;
            if (chkb) begin
                chk($sformatf("vec%0d busy_after_done", idx), int'(busy), 0);
                chkb = 1'b0;
            end
            if (read_en) begin
                if (nrd == 0) begin first = c; ss1 = sym_start; end
                last = c; sel = sym_end; nrd++;
            end
            if (sym_start) nss++;
            if (sym_end) nse++;
            if (done) begin ndn++; chkb = 1'b1; end
            @(negedge clock);
        end
        #1;
        chk($sformatf("vec%0d reads", idx), nrd, v.rd);
        chk($sformatf("vec%0d sym_starts", idx), nss, v.ss);
        chk($sformatf("vec%0d sym_ends", idx), nse, v.se);
        chk($sformatf("vec%0d done_pulses", idx), ndn, v.dn);
        chk($sformatf("vec%0d span", idx), (nrd > 0) ? last - first + 1 : 0, v.span);
        chk($sformatf("vec%0d err", idx), int'(err), int'(v.er));
        chk($sformatf("vec%0d busy_end", idx), int'(busy), int'(v.by));
        if (v.rd > 0) begin
            chk($sformatf("vec%0d start_on_first", idx), int'(ss1), 1);
            chk($sformatf("vec%0d end_on_last", idx), int'(sel), 1);
        end
    endtask

    initial begin
        //          mode  ms    bits last tog  rd  ss se dn span er    busy
        tbl[0]  = '{2'd0, 2'd0, 48,  1'b0, 1'b0, 24, 1, 1, 0, 24,  1'b0, 1'b1};
        tbl[1]  = '{2'd1, 2'd1, 96,  1'b0, 1'b0, 72, 1, 1, 0, 72,  1'b0, 1'b1};
        tbl[2]  = '{2'd1, 2'd1, 95,  1'b0, 1'b0, 0,  0, 0, 0, 0,   1'b0, 1'b1};
        tbl[3]  = '{2'd2, 2'd3, 288, 1'b0, 1'b0, 192, 1, 1, 0, 192, 1'b0, 1'b1};
        tbl[4]  = '{2'd2, 2'd3, 288, 1'b0, 1'b1, 192, 1, 1, 0, 383, 1'b0, 1'b1};
        tbl[5]  = '{2'd0, 2'd0, 11,  1'b1, 1'b0, 6,  1, 1, 1, 6,   1'b0, 1'b0};
        tbl[6]  = '{2'd3, 2'd0, 48,  1'b0, 1'b0, 24, 1, 1, 0, 24,  1'b0, 1'b1};
        tbl[7]  = '{2'd1, 2'd0, 32,  1'b1, 1'b0, 24, 1, 1, 1, 24,  1'b0, 1'b0};
        tbl[8]  = '{2'd0, 2'd0, 49,  1'b1, 1'b0, 25, 2, 2, 1, 26,  1'b0, 1'b0};
        tbl[9]  = '{2'd0, 2'd0, 501, 1'b0, 1'b0, 240, 10, 10, 0, 249, 1'b0, 1'b1};
        tbl[10] = '{2'd0, 2'd0, 502, 1'b0, 1'b0, 240, 10, 10, 0, 249, 1'b1, 1'b1};
        tbl[11] = '{2'd2, 2'd0, 10,  1'b1, 1'b0, 7,  1, 1, 1, 7,   1'b0, 1'b0};

        // Reset state: every output low.
        do_reset();
        #1;
        chk("reset_outputs", int'({read_en, sym_start, sym_end, busy, done, err}), 0);

        for (int k = 0; k < 12; k++) run_vec(k, 1'b1);

        // Overflow fires exactly on the 502nd slot and survives until reset.
        do_reset();
        mode = 2'd0; mod_sel = 2'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 501; i++) begin
            wr_valid = 1'b1;
            @(negedge clock);
        end
        wr_valid = 1'b0;
        #1;
        chk("ovf_at_501", int'(err), 0);
        wr_valid = 1'b1;
        @(negedge clock);
        wr_valid = 1'b0;
        #1;
        chk("ovf_at_502", int'(err), 1);
        repeat (5) @(negedge clock);
        #1;
        chk("ovf_sticky", int'(err), 1);
        do_reset();
        #1;
        chk("ovf_cleared", int'({err, busy}), 0);

        // Reset during the 10th read of a burst aborts at once, no done.
        begin
            int cnt;
            bit hit;
            cnt = 0; hit = 1'b0;
            do_reset();
            mode = 2'd0; mod_sel = 2'd0; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < 48; i++) begin
                wr_valid = 1'b1;
                @(negedge clock);
            end
            wr_valid = 1'b0;
            for (int c = 0; c < 100 && !hit; c++) begin
                dst_ready = 1'b1;
                #1;
                if (read_en) cnt++;
                if (cnt == 10) begin
                    reset = 1'b1;
                    @(negedge clock);
                    #1;
                    chk("abort_read_en", int'(read_en), 0);
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_done", int'(done), 0);
                    reset = 1'b0;
                    hit = 1'b1;
                end else begin
                    @(negedge clock);
                end
            end
            chk("abort_reached_10th_read", int'(hit), 1);
            run_vec(5, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
